// File: rtl/force_release_reg.sv
// force_release_reg: a data register with a hardware override path.
// Normal loads take `a`. An accepted override makes `x` track `ovr_val` for
// `ovr_len` cycles (0 = until `ovr_rel`). After that the register holds the last
// forced value until the next normal load.
// Optional build macro FORCE_RELEASE_REG_CNT_EN adds two ports: `ovr_cnt`
// (saturating count of accepted overrides) and `early_rel` (sticky flag for a
// release that cut a timed override short).

module force_release_reg #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned LEN_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic             load,
   input  logic             ovr_req,
   input  logic [WIDTH-1:0] ovr_val,
   input  logic [LEN_W-1:0] ovr_len,
   input  logic             ovr_rel,
   output logic             ovr_ack,
   output logic [WIDTH-1:0] x,
   output logic             forced,
   output logic             held
`ifdef FORCE_RELEASE_REG_CNT_EN
   ,
   output logic [7:0]       ovr_cnt,
   output logic             early_rel
`endif
);

   typedef enum logic [1:0] {
      StNormal = 2'd0,
      StForced = 2'd1,
      StHeld   = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   x_q, x_d;
   logic [LEN_W-1:0]   cnt_q, cnt_d;
   logic               ack_q, ack_d;
   logic               forced_q, held_q;
   logic               accept;
   logic               cnt_is_one;
   logic               rel_exit;

   assign cnt_is_one = (cnt_q == LEN_W'(1));

   // The release strobe only matters once the override is already in effect.
   assign rel_exit = (state_q == StForced) && ovr_rel;

   // Next-state, data path and override bookkeeping.
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      cnt_d   = cnt_q;
      ack_d   = 1'b0;
      accept  = 1'b0;

      unique case (state_q)
         StNormal, StHeld: begin
            // A request outranks a load; acceptance re-arms from HELD as well.
            if (ovr_req) begin
               accept  = 1'b1;
               ack_d   = 1'b1;
               x_d     = ovr_val;
               cnt_d   = ovr_len;
               state_d = StForced;
            end else if (load) begin
               x_d     = a;
               state_d = StNormal;
            end
         end

         StForced: begin
            // x keeps tracking the override value, including on the exit edge.
            x_d = ovr_val;
            if (cnt_q != '0) begin
               cnt_d = cnt_q - LEN_W'(1);
            end
            if (rel_exit || cnt_is_one) begin
               state_d = StHeld;
               cnt_d   = '0;
            end
         end

         default: begin
            state_d = StNormal;
            cnt_d   = '0;
         end
      endcase
   end

   // State and data registers; reset drops any override immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StNormal;
         x_q      <= '0;
         cnt_q    <= '0;
         ack_q    <= 1'b0;
         forced_q <= 1'b0;
         held_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         cnt_q    <= cnt_d;
         ack_q    <= ack_d;
         forced_q <= (state_d == StForced);
         held_q   <= (state_d == StHeld);
      end
   end

   assign x       = x_q;
   assign ovr_ack = ack_q;
   assign forced  = forced_q;
   assign held    = held_q;

`ifdef FORCE_RELEASE_REG_CNT_EN
   logic [7:0] ovr_cnt_q;
   logic       early_rel_q;

   // Saturating accept counter and sticky early-release flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovr_cnt_q   <= 8'd0;
         early_rel_q <= 1'b0;
      end else begin
         if (accept && (ovr_cnt_q != 8'hFF)) begin
            ovr_cnt_q <= ovr_cnt_q + 8'd1;
         end
         // cnt of 0 is an indefinite override, so releasing it is not early.
         if (rel_exit && (cnt_q > LEN_W'(1))) begin
            early_rel_q <= 1'b1;
         end
      end
   end

   assign ovr_cnt   = ovr_cnt_q;
   assign early_rel = early_rel_q;
`else
   // Statistics ports and their counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_force_release_reg.sv
// Self-checking bench for force_release_reg: directed steps followed by a
// randomized phase, all compared against a cycle-level behavioural model.

module tb_force_release_reg;

   localparam int NRM = 0;
   localparam int FRC = 1;
   localparam int HLD = 2;

   logic       clk;
   logic       rst_n;
   logic [7:0] a;
   logic       load;
   logic       ovr_req;
   logic [7:0] ovr_val;
   logic [7:0] ovr_len;
   logic       ovr_rel;
   logic       ovr_ack;
   logic [7:0] x;
   logic       forced;
   logic       held;
`ifdef FORCE_RELEASE_REG_CNT_EN
   logic [7:0] ovr_cnt;
   logic       early_rel;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   // Behavioural model state: mode, output value, forced cycles left (0 = forever).
   int       m_mode;
   logic [7:0] m_x;
   int       m_left;
   bit       m_ack;
   int       m_acc;
   bit       m_early;

   force_release_reg #(
      .WIDTH(8),
      .LEN_W(8)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .a        (a),
      .load     (load),
      .ovr_req  (ovr_req),
      .ovr_val  (ovr_val),
      .ovr_len  (ovr_len),
      .ovr_rel  (ovr_rel),
      .ovr_ack  (ovr_ack),
      .x        (x),
      .forced   (forced),
      .held     (held)
`ifdef FORCE_RELEASE_REG_CNT_EN
      ,
      .ovr_cnt  (ovr_cnt),
      .early_rel(early_rel)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_mode  = NRM;
      m_x     = 8'h00;
      m_left  = 0;
      m_ack   = 1'b0;
      m_acc   = 0;
      m_early = 1'b0;
   endtask

   // One clock edge of the reference behaviour, using the current inputs.
   task automatic model_edge();
      bit acc;
      acc = 1'b0;
      if (m_mode == FRC) begin
         m_x = ovr_val;
         if (ovr_rel) begin
            if (m_left > 1) m_early = 1'b1;
            m_mode = HLD;
         end else if (m_left != 0) begin
            m_left = m_left - 1;
            if (m_left == 0) m_mode = HLD;
         end
      end else if (ovr_req) begin
         acc    = 1'b1;
         m_x    = ovr_val;
         m_left = int'(ovr_len);
         m_mode = FRC;
      end else if (load) begin
         m_x    = a;
         m_mode = NRM;
      end
      m_ack = acc;
      if (acc && m_acc < 255) m_acc = m_acc + 1;
   endtask

   task automatic check_all();
      chk("x", 32'(x), 32'(m_x));
      chk("forced", 32'(forced), 32'(m_mode == FRC));
      chk("held", 32'(held), 32'(m_mode == HLD));
      chk("ovr_ack", 32'(ovr_ack), 32'(m_ack));
`ifdef FORCE_RELEASE_REG_CNT_EN
      chk("ovr_cnt", 32'(ovr_cnt), 32'(m_acc));
      chk("early_rel", 32'(early_rel), 32'(m_early));
`endif
   endtask

   // Advance model and DUT by one edge, then compare away from the edge.
   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
      check_all();
   endtask

   initial begin
      rst_n   = 1'b0;
      a       = 8'h00;
      load    = 1'b0;
      ovr_req = 1'b0;
      ovr_val = 8'h00;
      ovr_len = 8'h00;
      ovr_rel = 1'b0;
      model_reset();

      // Reset state.
      #12;
      chk("rst_x", 32'(x), 32'h0);
      chk("rst_forced", 32'(forced), 32'h0);
      chk("rst_held", 32'(held), 32'h0);
      chk("rst_ack", 32'(ovr_ack), 32'h0);
      #1 rst_n = 1'b1;

      // Plain load.
      a = 8'h3C; load = 1'b1;
      tick();
      chk("load_x", 32'(x), 32'h3C);
      load = 1'b0;
      tick();
      tick();
      chk("load_no_ack", 32'(ovr_ack), 32'h0);

      // Timed override of three cycles.
      ovr_req = 1'b1; ovr_len = 8'd3; ovr_val = 8'hA0;
      tick();
      chk("timed_ack", 32'(ovr_ack), 32'h1);
      chk("timed_x0", 32'(x), 32'hA0);
      ovr_req = 1'b0; ovr_val = 8'hA1;
      tick();
      chk("timed_x1", 32'(x), 32'hA1);
      chk("timed_ack_once", 32'(ovr_ack), 32'h0);
      ovr_val = 8'hA2;
      tick();
      chk("timed_x2", 32'(x), 32'hA2);
      chk("timed_forced3", 32'(forced), 32'h1);
      tick();
      chk("timed_held", 32'(held), 32'h1);
      chk("timed_held_x", 32'(x), 32'hA2);
      a = 8'h55; load = 1'b1;
      tick();
      chk("reload_x", 32'(x), 32'h55);
      chk("reload_normal", 32'(held), 32'h0);
      load = 1'b0;

      // Indefinite override with explicit release.
      ovr_req = 1'b1; ovr_len = 8'd0; ovr_val = 8'hFF;
      tick();
      ovr_req = 1'b0;
      for (int i = 0; i < 20; i++) tick();
      chk("indef_forced", 32'(forced), 32'h1);
      ovr_rel = 1'b1;
      tick();
      ovr_rel = 1'b0;
      chk("indef_held", 32'(held), 32'h1);
      chk("indef_x", 32'(x), 32'hFF);

      // Request beats load; load ignored while forced.
      a = 8'h00; load = 1'b1;
      tick();
      a = 8'h11; ovr_req = 1'b1; ovr_val = 8'h22; ovr_len = 8'd2;
      tick();
      chk("prio_x", 32'(x), 32'h22);
      chk("prio_ack", 32'(ovr_ack), 32'h1);
      ovr_req = 1'b0; a = 8'h33;
      tick();
      chk("forced_load_ign", 32'(x), 32'h22);
      load = 1'b0;
      tick();
      tick();

      // Asynchronous reset between edges while forced.
      ovr_req = 1'b1; ovr_val = 8'h77; ovr_len = 8'd0;
      tick();
      ovr_req = 1'b0;
      tick();
      chk("pre_rst_x", 32'(x), 32'h77);
      #3 rst_n = 1'b0;
      #1;
      model_reset();
      chk("async_x", 32'(x), 32'h0);
      chk("async_forced", 32'(forced), 32'h0);
      #2 rst_n = 1'b1;

`ifdef FORCE_RELEASE_REG_CNT_EN
      // Three accepts; the second is released with four cycles still left.
      ovr_req = 1'b1; ovr_len = 8'd2; ovr_val = 8'h01;
      tick();
      ovr_req = 1'b0;
      tick();
      tick();
      ovr_req = 1'b1; ovr_len = 8'd6;
      tick();
      ovr_req = 1'b0;
      tick();
      tick();
      chk("early_pre", 32'(early_rel), 32'h0);
      ovr_rel = 1'b1;
      tick();
      ovr_rel = 1'b0;
      ovr_req = 1'b1; ovr_len = 8'd1;
      tick();
      ovr_req = 1'b0;
      tick();
      chk("cnt_three", 32'(ovr_cnt), 32'd3);
      chk("early_set", 32'(early_rel), 32'h1);
`endif

      // Randomized phase against the model.
      for (int i = 0; i < 400; i++) begin
         a       = 8'($urandom);
         ovr_val = 8'($urandom);
         load    = ($urandom_range(0, 9) < 3);
         ovr_req = ($urandom_range(0, 9) < 2);
         ovr_rel = ($urandom_range(0, 9) < 1);
         ovr_len = 8'($urandom_range(0, 5));
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
